// File: rtl/immediate_encoder_pkg.sv
// Shared constants, state encoding and helpers for the rotated-immediate encoder.
package immediate_encoder_pkg;

  localparam int REGISTER_LEN = 32;
  localparam int IMM_WIDTH    = 8;
  localparam int ROT_WIDTH    = 4;
  localparam int SHIFT_OP_W   = ROT_WIDTH + IMM_WIDTH;

  typedef enum logic [1:0] {
    IMM_ENC_IDLE   = 2'd0,
    IMM_ENC_SEARCH = 2'd1,
    IMM_ENC_DONE   = 2'd2
  } enc_state_t;

  // True when a rotated candidate fits entirely in the imm8 field.
  function automatic logic fits_imm(input logic [REGISTER_LEN-1:0] cand);
    return cand[REGISTER_LEN-1:IMM_WIDTH] == '0;
  endfunction

endpackage

// File: rtl/immediate_encoder_rotate_left_even.sv
// Combinational rotate-left by an even amount (2*rot), rotation wraps modulo 32.
module rotate_left_even
  import immediate_encoder_pkg::*;
(
  input  logic [REGISTER_LEN-1:0] data,
  input  logic [ROT_WIDTH-1:0]    rot,
  output logic [REGISTER_LEN-1:0] result
);

  logic [4:0] amt;
  logic [5:0] back_amt;

  // 2*rot in 5 bits; a zero amount leaves the right-shift term at a full 32-bit shift, i.e. zero.
  always_comb begin
    amt      = {rot, 1'b0};
    back_amt = 6'd32 - {1'b0, amt};
    result   = (data << amt) | (data >> back_amt);
  end

endmodule

// File: rtl/immediate_encoder.sv
// Iterative search for {rotate_imm, imm8} such that value == ror(imm8, 2*rotate_imm).
// Rotations are tried in ascending order so the canonical (smallest) rotate_imm wins.
module immediate_encoder
  import immediate_encoder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REGISTER_LEN-1:0] value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SHIFT_OP_W-1:0]   shift_operand,
  output logic                    encodable
);

  enc_state_t              state, state_n;
  logic [ROT_WIDTH-1:0]    rot_cnt, rot_cnt_n;
  logic [REGISTER_LEN-1:0] value_q, value_n;
  logic [SHIFT_OP_W-1:0]   shift_operand_n;
  logic                    encodable_n;
  logic                    out_valid_n;
  logic [REGISTER_LEN-1:0] cand;

  rotate_left_even u_rol (
    .data   (value_q),
    .rot    (rot_cnt),
    .result (cand)
  );

  assign in_ready = (state == IMM_ENC_IDLE);

  // State and result registers; reset forces everything back to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IMM_ENC_IDLE;
      rot_cnt       <= '0;
      value_q       <= '0;
      shift_operand <= '0;
      encodable     <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      state         <= state_n;
      rot_cnt       <= rot_cnt_n;
      value_q       <= value_n;
      shift_operand <= shift_operand_n;
      encodable     <= encodable_n;
      out_valid     <= out_valid_n;
    end
  end

  // Next-state and next-result logic; flush overrides every transition.
  always_comb begin
    state_n         = state;
    rot_cnt_n       = rot_cnt;
    value_n         = value_q;
    shift_operand_n = shift_operand;
    encodable_n     = encodable;
    out_valid_n     = out_valid;

    if (flush) begin
      state_n         = IMM_ENC_IDLE;
      out_valid_n     = 1'b0;
      encodable_n     = 1'b0;
      shift_operand_n = '0;
    end else begin
      unique case (state)
        IMM_ENC_IDLE: begin
          if (in_valid) begin
            value_n   = value;
            rot_cnt_n = '0;
            state_n   = IMM_ENC_SEARCH;
          end
        end
        IMM_ENC_SEARCH: begin
          if (fits_imm(cand)) begin
            shift_operand_n = {rot_cnt, cand[IMM_WIDTH-1:0]};
            encodable_n     = 1'b1;
            out_valid_n     = 1'b1;
            state_n         = IMM_ENC_DONE;
          end else if (rot_cnt == '1) begin
            shift_operand_n = '0;
            encodable_n     = 1'b0;
            out_valid_n     = 1'b1;
            state_n         = IMM_ENC_DONE;
          end else begin
            rot_cnt_n = rot_cnt + 1'b1;
          end
        end
        IMM_ENC_DONE: begin
          if (out_ready) begin
            out_valid_n = 1'b0;
            state_n     = IMM_ENC_IDLE;
          end
        end
        default: state_n = IMM_ENC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// Bench for immediate_encoder: directed cases, backpressure, flush, async reset, random sweep.
module tb_immediate_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] value = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] shift_operand;
  logic        encodable;

  int n_checks = 0;
  int n_fail   = 0;

  immediate_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .value         (value),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .shift_operand (shift_operand),
    .encodable     (encodable)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    int k;
    k = s % 32;
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  // Reference: smallest r such that some imm8 rotated right by 2r equals v.
  task automatic model(input logic [31:0] v, output logic enc, output logic [11:0] so, output int lat);
    logic [31:0] imm;
    enc = 1'b0; so = '0; lat = 16;
    for (int r = 0; r < 16; r++) begin
      imm = ror32(v, 32 - 2 * r);
      if (imm < 32'd256 && ror32(imm, 2 * r) == v) begin
        enc = 1'b1;
        so  = {r[3:0], imm[7:0]};
        lat = r + 1;
        break;
      end
    end
  endtask

  // Present v at the next edge, scramble value afterwards, and count edges until out_valid.
  task automatic run_encode(input logic [31:0] v, output logic enc, output logic [11:0] so, output int lat);
    in_valid = 1'b1;
    value    = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    value    = $urandom;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    enc = encodable;
    so  = shift_operand;
  endtask

  task automatic finish_handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, encodable, shift_operand} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b enc=%b so=%h, want rdy=1 vld=0 enc=0 so=000",
               in_ready, out_valid, encodable, shift_operand);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vals [5] = '{32'h000000FF, 32'hFF000000, 32'hF000000F, 32'h000003FC, 32'h00000101};
    logic [11:0] exp_so [5] = '{12'h0FF, 12'h4FF, 12'h2FF, 12'hFFF, 12'h000};
    logic        exp_en [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int          exp_lat[5] = '{1, 5, 3, 16, 16};
    logic enc; logic [11:0] so; int lat;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_ready[%0d]: got %b want 1", i, in_ready);
      end
      run_encode(vals[i], enc, so, lat);
      n_checks++;
      if (enc !== exp_en[i] || so !== exp_so[i]) begin
        n_fail++;
        $display("FAIL directed_result %h: got enc=%b so=%h want enc=%b so=%h", vals[i], enc, so, exp_en[i], exp_so[i]);
      end
      n_checks++;
      if (lat != exp_lat[i]) begin
        n_fail++;
        $display("FAIL directed_latency %h: got %0d want %0d", vals[i], lat, exp_lat[i]);
      end
      finish_handshake();
    end
  endtask

  task automatic test_backpressure();
    logic enc; logic [11:0] so; int lat;
    out_ready = 1'b0;
    run_encode(32'hFF000000, enc, so, lat);
    n_checks++;
    if (lat != 5 || so !== 12'h4FF || enc !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_result: got lat=%0d so=%h enc=%b want lat=5 so=4ff enc=1", lat, so, enc);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, encodable, shift_operand} !== {1'b1, 1'b0, 1'b1, 12'h4FF}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b enc=%b so=%h want vld=1 rdy=0 enc=1 so=4ff",
                 i, out_valid, in_ready, encodable, shift_operand);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    int seen;
    in_valid = 1'b1;
    value    = 32'h00000101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_quiet: got %0d bad cycles want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    value    = 32'h00000101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, encodable, shift_operand} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b vld=%b enc=%b so=%h want rdy=1 vld=0 enc=0 so=000",
               in_ready, out_valid, encodable, shift_operand);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random_sweep();
    logic [31:0] v;
    logic enc, e_enc; logic [11:0] so, e_so; int lat, e_lat;
    for (int i = 0; i < 3000; i++) begin
      if (i % 2 == 0) v = ror32($urandom_range(0, 255), 2 * $urandom_range(0, 15));
      else            v = $urandom;
      model(v, e_enc, e_so, e_lat);
      run_encode(v, enc, so, lat);
      n_checks++;
      if (enc !== e_enc || so !== e_so) begin
        n_fail++;
        $display("FAIL rand_result %h: got enc=%b so=%h want enc=%b so=%h", v, enc, so, e_enc, e_so);
      end
      n_checks++;
      if (lat != e_lat) begin
        n_fail++;
        $display("FAIL rand_latency %h: got %0d want %0d", v, lat, e_lat);
      end
      if (enc === 1'b1) begin
        n_checks++;
        if (ror32({24'h0, so[7:0]}, 2 * int'(so[11:8])) !== v) begin
          n_fail++;
          $display("FAIL rand_decode %h: so=%h decodes to %h", v, so, ror32({24'h0, so[7:0]}, 2 * int'(so[11:8])));
        end
      end
      finish_handshake();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
